// File: rtl/text_blitter.sv
// text_blitter: draws 8x16 char_decoder glyphs into a framebuffer
// at a self-managed text cursor (advance, line/screen wrap, newline).
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ch, ch_valid/ch_ready ASCII character stream (valid/ready)
//   home                  cursor to (0,0), honoured only when idle
//   fg_colour, bg_colour  glyph/background colour, sampled at accept
//   dec_char, dec_pixels  code to / bitmap from char_decoder
//   vga_x/y/colour/plot   one registered pixel write per cycle
//   busy                  high whenever not idle
//   cursor_x, cursor_y    top-left of the next glyph
//
// Build option: define TEXT_BG_EN to also write background pixels;
// otherwise the background is transparent (same cycle timing).

module text_blitter #(
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter int X_W      = 9,
   parameter int Y_W      = 8,
   parameter int COLOUR_W = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [6:0]          ch,
   input  logic                ch_valid,
   output logic                ch_ready,
   input  logic                home,
   input  logic [COLOUR_W-1:0] fg_colour,
   input  logic [COLOUR_W-1:0] bg_colour,
   output logic [6:0]          dec_char,
   input  logic [127:0]        dec_pixels,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   output logic                busy,
   output logic [X_W-1:0]      cursor_x,
   output logic [Y_W-1:0]      cursor_y
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAW,
      S_ADVANCE
   } state_t;

   // Last legal glyph origin, kept one bit wider so the
   // compare happens before the sum is truncated.
   localparam logic [X_W:0] X_LAST = (X_W+1)'(SCREEN_W - 8);
   localparam logic [Y_W:0] Y_LAST = (Y_W+1)'(SCREEN_H - 16);

   state_t              r_state;
   logic [6:0]          r_dec_char;
   logic [6:0]          r_k;
   logic [127:0]        r_glyph;
   logic [COLOUR_W-1:0] r_fg;
   logic [COLOUR_W-1:0] r_bg;
   logic                r_nl;
   logic [X_W-1:0]      r_cx;
   logic [Y_W-1:0]      r_cy;
   logic [X_W-1:0]      r_vga_x;
   logic [Y_W-1:0]      r_vga_y;
   logic [COLOUR_W-1:0] r_vga_colour;
   logic                r_vga_plot;

   logic                w_accept;
   logic                w_load;
   logic [6:0]          w_k;
   logic                w_bit;
   logic                w_plot;
   logic [COLOUR_W-1:0] w_colour;
   logic [X_W-1:0]      w_px;
   logic [Y_W-1:0]      w_py;
   logic [X_W:0]        w_nx;
   logic                w_xwrap;
   logic [Y_W:0]        w_ny;
   logic                w_ywrap;
   logic [X_W-1:0]      w_cx_nxt;
   logic [Y_W-1:0]      w_cy_nxt;

   assign ch_ready = (r_state == S_IDLE) && !home && !reset;
   assign w_accept = ch_valid && ch_ready;
   assign w_load   = (r_state == S_LOAD);

   // Outputs are registered, so each cycle prepares the pixel shown
   // next: pixel 0 straight from the decoder during LOAD, then k+1.
   // The glyph shifts left so bit 127 is always the next pixel.
   assign w_k   = w_load ? 7'd0 : r_k + 7'd1;
   assign w_bit = w_load ? dec_pixels[127] : r_glyph[127];
   assign w_px  = r_cx + {{(X_W-3){1'b0}}, w_k[2:0]};
   assign w_py  = r_cy + {{(Y_W-4){1'b0}}, w_k[6:3]};

`ifdef TEXT_BG_EN
   assign w_plot = 1'b1;
`else
   assign w_plot = w_bit;
`endif

   assign w_colour = w_bit ? r_fg : r_bg;

   assign w_nx    = {1'b0, r_cx} + {{(X_W-3){1'b0}}, 4'd8};
   assign w_xwrap = r_nl || (w_nx > X_LAST);
   assign w_ny    = {1'b0, r_cy}
                  + (w_xwrap ? {{(Y_W-4){1'b0}}, 5'd16} : '0);
   assign w_ywrap = w_ny > Y_LAST;

   assign w_cx_nxt = w_xwrap ? '0 : w_nx[X_W-1:0];
   assign w_cy_nxt = w_ywrap ? '0 : w_ny[Y_W-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_dec_char   <= '0;
         r_k          <= '0;
         r_glyph      <= '0;
         r_fg         <= '0;
         r_bg         <= '0;
         r_nl         <= 1'b0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_vga_x      <= '0;
         r_vga_y      <= '0;
         r_vga_colour <= '0;
         r_vga_plot   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (home) begin
                  r_cx <= '0;
                  r_cy <= '0;
               end else if (w_accept) begin
                  r_dec_char <= ch;
                  r_fg       <= fg_colour;
                  r_bg       <= bg_colour;
                  r_nl       <= (ch == 7'h0A);
                  r_state    <= (ch == 7'h0A) ? S_ADVANCE : S_LOAD;
               end
            end
            S_LOAD: begin
               r_glyph      <= {dec_pixels[126:0], 1'b0};
               r_k          <= 7'd0;
               r_vga_x      <= w_px;
               r_vga_y      <= w_py;
               r_vga_colour <= w_colour;
               r_vga_plot   <= w_plot;
               r_state      <= S_DRAW;
            end
            S_DRAW: begin
               if (r_k == 7'd127) begin
                  r_vga_plot <= 1'b0;
                  r_state    <= S_ADVANCE;
               end else begin
                  r_k          <= w_k;
                  r_glyph      <= {r_glyph[126:0], 1'b0};
                  r_vga_x      <= w_px;
                  r_vga_y      <= w_py;
                  r_vga_colour <= w_colour;
                  r_vga_plot   <= w_plot;
               end
            end
            S_ADVANCE: begin
               r_cx    <= w_cx_nxt;
               r_cy    <= w_cy_nxt;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dec_char   = r_dec_char;
   assign vga_x      = r_vga_x;
   assign vga_y      = r_vga_y;
   assign vga_colour = r_vga_colour;
   assign vga_plot   = r_vga_plot;
   assign busy       = (r_state != S_IDLE);
   assign cursor_x   = r_cx;
   assign cursor_y   = r_cy;

endmodule

// File: tb/tb_text_blitter.sv
// Testbench for text_blitter: directed character stream, per-cycle
// comparison against a pixel-list model of the glyph drawing rules.

module tb_text_blitter;

   localparam int SW = 320;
   localparam int SH = 240;
`ifdef TEXT_BG_EN
   localparam bit BG_EN = 1'b1;
`else
   localparam bit BG_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset;
   logic [6:0]   ch;
   logic         ch_valid;
   logic         ch_ready;
   logic         home;
   logic [2:0]   fg_colour;
   logic [2:0]   bg_colour;
   logic [6:0]   dec_char;
   logic [127:0] dec_pixels;
   logic [8:0]   vga_x;
   logic [7:0]   vga_y;
   logic [2:0]   vga_colour;
   logic         vga_plot;
   logic         busy;
   logic [8:0]   cursor_x;
   logic [7:0]   cursor_y;

   always #5 clock = ~clock;

   text_blitter #(
      .SCREEN_W(SW), .SCREEN_H(SH), .X_W(9), .Y_W(8), .COLOUR_W(3)
   ) dut (
      .clock(clock), .reset(reset),
      .ch(ch), .ch_valid(ch_valid), .ch_ready(ch_ready),
      .home(home),
      .fg_colour(fg_colour), .bg_colour(bg_colour),
      .dec_char(dec_char), .dec_pixels(dec_pixels),
      .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot),
      .busy(busy),
      .cursor_x(cursor_x), .cursor_y(cursor_y)
   );

   // Stand-in for char_decoder (combinational ROM).
   function automatic logic [127:0] font(input logic [6:0] c);
      case (c)
         7'h41: return {8'h00, 8'h00, 8'h38, 8'h6C,
                        8'hC6, 8'hC6, 8'hFE, 8'hC6,
                        8'hC6, 8'hC6, 8'hC6, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00};
         7'h42: return {8'hFC, 8'hC6, 8'hC6, 8'hFC,
                        8'hC6, 8'hC6, 8'hFC, {9{8'h00}}};
         7'h20: return 128'h0;
         default: return {8{16'hAA55}};
      endcase
   endfunction

   assign dec_pixels = font(dec_char);

   typedef struct packed {
      logic       plot;
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] col;
   } pix_t;

   pix_t exp_q[int];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_plots = 0;
   int   acc_edge = 0;
   int   mx = 0;
   int   my = 0;
   int   first_x = -1;
   int   first_y = -1;
   bit   seen_first = 1'b0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Every cycle: the DUT must show exactly what the model scheduled.
   always @(negedge clock) begin
      pix_t e;
      if (vga_plot === 1'b1) begin
         n_plots++;
         if (!seen_first) begin
            seen_first = 1'b1;
            first_x = int'(vga_x);
            first_y = int'(vga_y);
         end
      end
      if (exp_q.exists(cyc)) begin
         e = exp_q[cyc];
         chk("plot", vga_plot, e.plot);
         if (e.plot) begin
            chk("x", vga_x, e.x);
            chk("y", vga_y, e.y);
            chk("colour", vga_colour, e.col);
         end
         exp_q.delete(cyc);
      end else begin
         chk("plot_outside_draw", vga_plot, 0);
      end
   end

   task automatic model_adv(input bit nl);
      if (nl) begin
         mx = 0;
         my = my + 16;
      end else begin
         mx = mx + 8;
         if (mx > SW - 8) begin
            mx = 0;
            my = my + 16;
         end
      end
      if (my > SH - 16) my = 0;
   endtask

   // Called just after the accepting edge: schedule the 128 pixels.
   task automatic model_accept(input logic [6:0] c,
                               input logic [2:0] f,
                               input logic [2:0] b);
      logic [127:0] g;
      pix_t e;
      acc_edge = cyc;
      if (c == 7'h0A) begin
         model_adv(1'b1);
      end else begin
         g = font(c);
         for (int k = 0; k < 128; k++) begin
            int r, cc;
            logic bv;
            r = k / 8;
            cc = k % 8;
            bv = g[127 - 8*r - cc];
            e.plot = BG_EN ? 1'b1 : bv;
            e.x = 9'(mx + cc);
            e.y = 8'(my + r);
            e.col = bv ? f : b;
            exp_q[acc_edge + 1 + k] = e;
         end
         model_adv(1'b0);
      end
   endtask

   task automatic wait_idle(input int lat);
      int n, nb;
      n = 0;
      nb = 0;
      @(negedge clock);
      while (ch_ready !== 1'b1 && n < 400) begin
         if (busy === 1'b1) nb++;
         n++;
         @(negedge clock);
      end
      chk("latency", cyc - acc_edge, lat);
      chk("busy_cycles", nb, lat);
      chk("cursor_x", cursor_x, mx);
      chk("cursor_y", cursor_y, my);
   endtask

   task automatic send(input logic [6:0] c, input logic [2:0] f,
                       input logic [2:0] b, input int lat,
                       input bit wait_done);
      int w;
      @(negedge clock);
      ch = c;
      fg_colour = f;
      bg_colour = b;
      ch_valid = 1'b1;
      seen_first = 1'b0;
      w = 0;
      while (ch_ready !== 1'b1 && w < 300) begin
         @(negedge clock);
         w++;
      end
      if (ch_ready !== 1'b1) begin
         chk("accept_timeout", 0, 1);
         ch_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      ch_valid = 1'b0;
      model_accept(c, f, b);
      if (wait_done) wait_idle(lat);
   endtask

   task automatic do_home();
      @(negedge clock);
      home = 1'b1;
      @(posedge clock);
      #1;
      home = 1'b0;
      mx = 0;
      my = 0;
      @(negedge clock);
      chk("home_x", cursor_x, 0);
      chk("home_y", cursor_y, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n0, h, n;
      reset = 1'b1;
      ch = '0;
      ch_valid = 1'b0;
      home = 1'b0;
      fg_colour = '0;
      bg_colour = '0;
      repeat (3) @(negedge clock);
      chk("rst_ready", ch_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_plot", vga_plot, 0);
      chk("rst_vx", vga_x, 0);
      chk("rst_vy", vga_y, 0);
      chk("rst_vcol", vga_colour, 0);
      chk("rst_cx", cursor_x, 0);
      chk("rst_cy", cursor_y, 0);
      chk("rst_dec", dec_char, 0);
      reset = 1'b0;
      #1;
      chk("ready_after_rst", ch_ready, 1);

      // 'A', fg 7, bg 0
      n0 = n_plots;
      send(7'h41, 3'd7, 3'd0, 130, 1'b1);
      chk("A_plots", n_plots - n0, BG_EN ? 128 : 38);
      chk("A_first_x", first_x, BG_EN ? 0 : 2);
      chk("A_first_y", first_y, BG_EN ? 0 : 2);
      chk("A_cur_x", cursor_x, 8);
      chk("A_cur_y", cursor_y, 0);
      chk("A_dec_char", dec_char, 7'h41);

      n0 = n_plots;
      send(7'h20, 3'd3, 3'd1, 130, 1'b1);
      chk("space_plots", n_plots - n0, BG_EN ? 128 : 0);

      // 40 glyphs fill one line
      do_home();
      for (int i = 0; i < 40; i++) send(7'h42, 3'd5, 3'd2, 130, 1'b1);
      chk("B40_first_x", first_x, 312);
      chk("B40_first_y", first_y, 0);
      chk("B40_cur_x", cursor_x, 0);
      chk("B40_cur_y", cursor_y, 16);

      // bottom-right corner wraps to (0,0)
      for (int i = 0; i < 13; i++) send(7'h0A, 3'd0, 3'd0, 1, 1'b1);
      for (int i = 0; i < 39; i++) send(7'h42, 3'd6, 3'd1, 130, 1'b1);
      chk("corner_x", cursor_x, 312);
      chk("corner_y", cursor_y, 224);
      send(7'h42, 3'd6, 3'd1, 130, 1'b1);
      chk("scr_wrap_x", cursor_x, 0);
      chk("scr_wrap_y", cursor_y, 0);

      // newline on the last text row
      for (int i = 0; i < 14; i++) send(7'h0A, 3'd0, 3'd0, 1, 1'b1);
      send(7'h7F, 3'd2, 3'd5, 130, 1'b1);
      send(7'h41, 3'd4, 3'd3, 130, 1'b1);
      send(7'h42, 3'd1, 3'd6, 130, 1'b1);
      send(7'h7F, 3'd7, 3'd0, 130, 1'b1);
      send(7'h20, 3'd7, 3'd0, 130, 1'b1);
      chk("nl_pre_x", cursor_x, 40);
      chk("nl_pre_y", cursor_y, 224);
      n0 = n_plots;
      send(7'h0A, 3'd7, 3'd7, 1, 1'b1);
      chk("nl_plots", n_plots - n0, 0);
      chk("nl_wrap_x", cursor_x, 0);
      chk("nl_wrap_y", cursor_y, 0);

      // reset at pixel 60
      send(7'h42, 3'd7, 3'd2, 130, 1'b0);
      n = 0;
      @(negedge clock);
      while (cyc != acc_edge + 61 && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("k60_x", vga_x, 4);
      chk("k60_y", vga_y, 7);
      reset = 1'b1;
      #1;
      chk("ready_in_rst", ch_ready, 0);
      @(posedge clock);
      #1;
      for (int i = cyc; i < cyc + 200; i++)
         if (exp_q.exists(i)) exp_q.delete(i);
      mx = 0;
      my = 0;
      @(negedge clock);
      chk("post_rst_plot", vga_plot, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_x", cursor_x, 0);
      chk("post_rst_y", cursor_y, 0);
      reset = 1'b0;
      send(7'h41, 3'd6, 3'd1, 130, 1'b1);
      chk("after_rst_x", cursor_x, 8);
      chk("after_rst_y", cursor_y, 0);

      // home together with a pending character
      send(7'h0A, 3'd0, 3'd0, 1, 1'b1);
      send(7'h0A, 3'd0, 3'd0, 1, 1'b1);
      send(7'h42, 3'd3, 3'd4, 130, 1'b1);
      send(7'h42, 3'd3, 3'd4, 130, 1'b1);
      chk("pre_home_x", cursor_x, 16);
      chk("pre_home_y", cursor_y, 32);
      @(negedge clock);
      home = 1'b1;
      ch = 7'h41;
      fg_colour = 3'd3;
      bg_colour = 3'd4;
      ch_valid = 1'b1;
      seen_first = 1'b0;
      #1;
      chk("home_blocks", ch_ready, 0);
      @(posedge clock);
      #1;
      home = 1'b0;
      mx = 0;
      my = 0;
      h = cyc;
      @(negedge clock);
      chk("hv_cur_x", cursor_x, 0);
      chk("hv_cur_y", cursor_y, 0);
      chk("hv_ready", ch_ready, 1);
      @(posedge clock);
      #1;
      ch_valid = 1'b0;
      model_accept(7'h41, 3'd3, 3'd4);
      chk("hv_delay", acc_edge - h, 1);
      wait_idle(130);
      chk("hv_first_x", first_x, BG_EN ? 0 : 2);
      chk("hv_first_y", first_y, BG_EN ? 0 : 2);

      repeat (3) @(negedge clock);
      chk("model_drained", exp_q.num(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
